deadtime_gen_n: RTL and testbench

- Parametrised N-channel dead-time inserter for half-bridge gate drive.
- Sits between the PWM generator and the gate-driver pins.
- Per channel: takes high/low-side requests GH_IN/GL_IN and drives GH_OUT/GL_OUT.
- Guarantees both outputs of a channel are never high together, and enforces a runtime-programmable dead gap whenever conduction is handed between sides.
- Adds what the fixed 3-channel generation lacks: channel-count and counter-width parameters, runtime dead time, an enable input, and per-channel sticky shoot-through fault detection.

---
 rtl/deadtime_pkg.sv | 28 ++
 rtl/deadtime_ch.sv | 93 +++++++++
 rtl/deadtime_gen_n.sv | 38 +++
 tb/tb_deadtime_gen_n.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/deadtime_pkg.sv
// Shared types and constants for the N-channel dead-time inserter.
package deadtime_pkg;

  localparam int unsigned DT_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10,
    DEAD = 2'b11
  } dt_state_e;

  // Registered request pair is {gh, gl}
  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_L    = 2'b01;
  localparam logic [1:0] REQ_H    = 2'b10;
  localparam logic [1:0] REQ_ILL  = 2'b11;

  // Conduction state a request asks for; illegal maps to no conduction
  function automatic dt_state_e req_target(input logic [1:0] req);
    case (req)
      REQ_H:   return HIGH;
      REQ_L:   return LOW;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/deadtime_ch.sv
// One half-bridge channel: request register, conduction FSM, dead-time
// counter and sticky shoot-through fault flag.
module deadtime_ch
  import deadtime_pkg::*;
#(
  parameter int unsigned CNT_W = DT_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] dt_cycles,
  input  logic             gh_in,
  input  logic             gl_in,
  input  logic             fault_clr,
  output logic             gh_out,
  output logic             gl_out,
  output logic             fault
);

  dt_state_e        state_q, state_d;
  dt_state_e        target;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       req_q;
  logic             gh_d, gl_d, fault_d;

  assign target = req_target(req_q);

  // State register; outputs are flops written alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= REQ_NONE;
      gh_out  <= 1'b0;
      gl_out  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= {gh_in, gl_in};
      gh_out  <= gh_d;
      gl_out  <= gl_d;
      fault   <= fault_d;
    end
  end

  // Next-state and counter; dt_cycles only matters at the load edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = target;
        HIGH, LOW: begin
          if (target != state_q) begin
            if (dt_cycles == '0) begin
              state_d = target;
            end else begin
              state_d = DEAD;
              cnt_d   = dt_cycles;
            end
          end
        end
        DEAD: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = target;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the next state; fault set beats clear
  always_comb begin
    gh_d    = 1'b0;
    gl_d    = 1'b0;
    fault_d = fault & ~fault_clr;
    if (req_q == REQ_ILL) fault_d = 1'b1;
    case (state_d)
      HIGH:    gh_d = 1'b1;
      LOW:     gl_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/deadtime_gen_n.sv
// N-channel dead-time inserter between the PWM generator and gate drivers.
module deadtime_gen_n
  import deadtime_pkg::*;
#(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned CNT_W = DT_CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [CNT_W-1:0] DT_CYCLES,
  input  logic [N_CH-1:0]  GH_IN,
  input  logic [N_CH-1:0]  GL_IN,
  input  logic             FAULT_CLR,
  output logic [N_CH-1:0]  GH_OUT,
  output logic [N_CH-1:0]  GL_OUT,
  output logic [N_CH-1:0]  FAULT
);

  // Channels share only dead time, enable and fault clear
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    deadtime_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (RST_N),
      .en       (EN),
      .dt_cycles(DT_CYCLES),
      .gh_in    (GH_IN[i]),
      .gl_in    (GL_IN[i]),
      .fault_clr(FAULT_CLR),
      .gh_out   (GH_OUT[i]),
      .gl_out   (GL_OUT[i]),
      .fault    (FAULT[i])
    );
  end

endmodule

// File: tb/tb_deadtime_gen_n.sv
// Bench for deadtime_gen_n: directed sequences, a vector table and random
// stimulus, all compared against a cycle-level behavioural model.
module tb_deadtime_gen_n;

  localparam int unsigned NC = 3;
  localparam int unsigned CW = 8;

  logic          CLK;
  logic          RST_N;
  logic          EN;
  logic [CW-1:0] DT_CYCLES;
  logic [NC-1:0] GH_IN, GL_IN;
  logic          FAULT_CLR;
  logic [NC-1:0] GH_OUT, GL_OUT, FAULT;

  int checks = 0;
  int errors = 0;

  deadtime_gen_n #(.N_CH(NC), .CNT_W(CW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .EN       (EN),
    .DT_CYCLES(DT_CYCLES),
    .GH_IN    (GH_IN),
    .GL_IN    (GL_IN),
    .FAULT_CLR(FAULT_CLR),
    .GH_OUT   (GH_OUT),
    .GL_OUT   (GL_OUT),
    .FAULT    (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: conducting side (0 none, 1 high, 2 low), gap end time stamp
  int         m_side  [NC];
  bit         m_dead  [NC];
  longint     m_end   [NC];
  logic [1:0] m_req   [NC];
  bit         m_fault [NC];
  longint     m_edge;

  task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_side[c]  = 0;
      m_dead[c]  = 1'b0;
      m_end[c]   = 0;
      m_req[c]   = 2'b00;
      m_fault[c] = 1'b0;
    end
    m_edge = 0;
  endtask

  task automatic model_step(input logic en, input int dt, input logic clr,
                            input logic [NC-1:0] gh, input logic [NC-1:0] gl);
    for (int c = 0; c < NC; c++) begin
      int want;
      want = (m_req[c] == 2'b10) ? 1 : (m_req[c] == 2'b01) ? 2 : 0;
      m_fault[c] = (m_req[c] == 2'b11) || (m_fault[c] && !clr);
      if (!en) begin
        m_side[c] = 0;
        m_dead[c] = 1'b0;
      end else if (m_dead[c]) begin
        if (m_edge >= m_end[c]) begin
          m_dead[c] = 1'b0;
          m_side[c] = want;
        end
      end else if (m_side[c] == 0) begin
        m_side[c] = want;
      end else if (want != m_side[c]) begin
        if (dt == 0) begin
          m_side[c] = want;
        end else begin
          m_dead[c] = 1'b1;
          m_side[c] = 0;
          m_end[c]  = m_edge + longint'(dt);
        end
      end
      m_req[c] = {gh[c], gl[c]};
    end
    m_edge++;
  endtask

  task automatic model_check();
    logic [NC-1:0] eh, el, ef;
    for (int c = 0; c < NC; c++) begin
      eh[c] = (m_side[c] == 1);
      el[c] = (m_side[c] == 2);
      ef[c] = m_fault[c];
    end
    chk("model_gh", GH_OUT, eh);
    chk("model_gl", GL_OUT, el);
    chk("model_fault", FAULT, ef);
  endtask

  // One clock: advance the model with the pre-edge inputs, then sample
  task automatic cyc();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_step(EN, int'(DT_CYCLES), FAULT_CLR, GH_IN, GL_IN);
    #1;
    model_check();
  endtask

  always @(negedge CLK) begin
    checks++;
    assert ((GH_OUT & GL_OUT) == '0)
    else begin
      errors++;
      $display("FAIL overlap: gh %b gl %b at %0t", GH_OUT, GL_OUT, $time);
    end
  end

  typedef struct {
    logic [NC-1:0] gh;
    logic [NC-1:0] gl;
    logic          en;
    logic [CW-1:0] dt;
    logic          clr;
    logic [NC-1:0] egh;
    logic [NC-1:0] egl;
    logic [NC-1:0] ef;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int bad;
    // Rows start with ch0 HIGH, ch1 HIGH, ch2 LOW, no gap pending
    tbl[0]  = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b0, 3'b011, 3'b100, 3'b000};
    tbl[1]  = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b0, 3'b001, 3'b110, 3'b000};
    tbl[2]  = '{3'b101, 3'b110, 1'b1, 8'd0,   1'b0, 3'b001, 3'b110, 3'b000};
    tbl[3]  = '{3'b101, 3'b110, 1'b1, 8'd0,   1'b0, 3'b001, 3'b010, 3'b100};
    tbl[4]  = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b0, 3'b001, 3'b010, 3'b100};
    tbl[5]  = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b0, 3'b001, 3'b110, 3'b100};
    tbl[6]  = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b1, 3'b001, 3'b110, 3'b000};
    tbl[7]  = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b0, 3'b001, 3'b110, 3'b000};
    tbl[8]  = '{3'b101, 3'b110, 1'b1, 8'd0,   1'b1, 3'b001, 3'b110, 3'b000};
    tbl[9]  = '{3'b101, 3'b110, 1'b1, 8'd0,   1'b1, 3'b001, 3'b010, 3'b100};
    tbl[10] = '{3'b101, 3'b110, 1'b1, 8'd0,   1'b1, 3'b001, 3'b010, 3'b100};
    tbl[11] = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b1, 3'b001, 3'b010, 3'b100};
    tbl[12] = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b1, 3'b001, 3'b110, 3'b000};
    tbl[13] = '{3'b001, 3'b110, 1'b1, 8'd0,   1'b0, 3'b001, 3'b110, 3'b000};
    tbl[14] = '{3'b001, 3'b110, 1'b0, 8'd100, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[15] = '{3'b001, 3'b110, 1'b1, 8'd100, 1'b0, 3'b001, 3'b110, 3'b000};

    RST_N = 1'b0; EN = 1'b1; DT_CYCLES = 8'd100;
    GH_IN = '0; GL_IN = '0; FAULT_CLR = 1'b0;
    model_reset();
    repeat (3) cyc();
    chk("reset_gh", GH_OUT, 3'b000);
    chk("reset_gl", GL_OUT, 3'b000);
    chk("reset_fault", FAULT, 3'b000);
    @(negedge CLK);
    RST_N = 1'b1;

    // Turn-on from idle two edges after the request
    GH_IN = 3'b101; GL_IN = 3'b010;
    cyc();
    chk("t1_lat1_gh", GH_OUT, 3'b000);
    cyc();
    chk("t1_gh", GH_OUT, 3'b101);
    chk("t1_gl", GL_OUT, 3'b010);
    chk("t1_fault", FAULT, 3'b000);

    // Full hand-over with a 100-cycle gap
    GH_IN = 3'b010; GL_IN = 3'b101;
    cyc(); cyc();
    chk("t2_off_gh", GH_OUT, 3'b000);
    chk("t2_off_gl", GL_OUT, 3'b000);
    repeat (99) cyc();
    chk("t2_gap_gh", GH_OUT, 3'b000);
    chk("t2_gap_gl", GL_OUT, 3'b000);
    cyc();
    chk("t2_on_gh", GH_OUT, 3'b010);
    chk("t2_on_gl", GL_OUT, 3'b101);

    // Short opposite request during the gap: no GL pulse, full gap kept
    DT_CYCLES = 8'd0; GH_IN = 3'b011; GL_IN = 3'b100;
    cyc(); cyc();
    chk("t3_setup_gh", GH_OUT, 3'b011);
    chk("t3_setup_gl", GL_OUT, 3'b100);
    DT_CYCLES = 8'd100;
    bad = 0;
    for (int i = 1; i <= 102; i++) begin
      if (i == 1) begin GH_IN = 3'b010; GL_IN = 3'b101; end
      if (i == 4) begin GH_IN = 3'b011; GL_IN = 3'b100; end
      cyc();
      if (i >= 2 && i <= 101 && (GH_OUT[0] || GL_OUT[0])) bad++;
    end
    chk("t3_gap_quiet", NC'(bad != 0), 3'b000);
    chk("t3_on_gh", GH_OUT, 3'b011);
    chk("t3_on_gl", GL_OUT, 3'b100);

    // Zero dead time, illegal requests, fault clear and enable rows
    for (int i = 0; i < 16; i++) begin
      GH_IN = tbl[i].gh; GL_IN = tbl[i].gl; EN = tbl[i].en;
      DT_CYCLES = tbl[i].dt; FAULT_CLR = tbl[i].clr;
      cyc();
      chk($sformatf("vec%0d_gh", i), GH_OUT, tbl[i].egh);
      chk($sformatf("vec%0d_gl", i), GL_OUT, tbl[i].egl);
      chk($sformatf("vec%0d_fault", i), FAULT, tbl[i].ef);
    end
    FAULT_CLR = 1'b0;

    // Reset in the middle of a gap, then enable drop while conducting
    DT_CYCLES = 8'd100; GH_IN = 3'b111; GL_IN = 3'b000;
    cyc(); cyc();
    chk("t6_dead_gh", GH_OUT, 3'b001);
    chk("t6_dead_gl", GL_OUT, 3'b000);
    repeat (10) cyc();
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    chk("t6_async_gh", GH_OUT, 3'b000);
    chk("t6_async_gl", GL_OUT, 3'b000);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
    chk("t6_rel1_gh", GH_OUT, 3'b000);
    cyc();
    chk("t6_rel2_gh", GH_OUT, 3'b111);
    chk("t6_rel2_gl", GL_OUT, 3'b000);
    EN = 1'b0;
    cyc();
    chk("t6_en0_gh", GH_OUT, 3'b000);
    EN = 1'b1;
    cyc();
    chk("t6_en1_gh", GH_OUT, 3'b111);

    // Random traffic against the model, short gaps so hand-overs complete
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < NC; c++) begin
          int r;
          r = int'($urandom_range(0, 15));
          if (r == 0) begin GH_IN[c] = 1'b1; GL_IN[c] = 1'b1; end
          else if (r <= 5) begin GH_IN[c] = 1'b1; GL_IN[c] = 1'b0; end
          else if (r <= 10) begin GH_IN[c] = 1'b0; GL_IN[c] = 1'b1; end
          else begin GH_IN[c] = 1'b0; GL_IN[c] = 1'b0; end
        end
      end
      DT_CYCLES = CW'($urandom_range(0, 6));
      EN        = ($urandom_range(0, 19) != 0);
      FAULT_CLR = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
